// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch stage
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int INS_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INS = 32'h00000013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
    } fetch_entry_t;
    typedef enum logic {FS_BOOT, FS_RUN} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, used for PC tags and fetched words
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int Depth = 2,
    parameter type T = fetch_entry_t
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  T                        din,
    output T                        dout,
    output logic [$clog2(Depth):0]  count,
    output logic                    empty,
    output logic                    full
);
    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;
    T mem [Depth];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    always_ff @(posedge clk)
        if (push && !flush)
            mem[wr_ptr] <= din;
    always_comb begin
        dout = mem[rd_ptr];
        empty = count == '0;
        full = count == CW'(Depth);
    end
    always @(posedge clk)
        if (!rst && !flush) begin
            assert (!(push && full && !pop));
            assert (!(pop && empty));
        end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch PC, in-order imem requests and buffered word delivery to decode
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter int WordSize = 32,
    parameter logic [WordSize-1:0] ResetVector = '0,
    parameter int Depth = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                branch_taken,
    input  logic [WordSize-1:0] branch_addr,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [WordSize-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [WordSize-1:0] imem_rsp_data,
    output logic                ins_valid,
    input  logic                ins_ready,
    output logic [WordSize-1:0] ins,
    output logic [WordSize-1:0] pc_out
);
    localparam int CW = $clog2(Depth) + 1;
    typedef logic [CW:0] occ_t;
    localparam occ_t CAP = occ_t'(Depth);
    fetch_state_t state, state_next;
    logic [WordSize-1:0] fetch_pc, tag_head;
    logic [CW-1:0] drop, drop_next, owed, inflight, fifo_count;
    logic req_fire, rsp_keep, ins_fire, tag_empty, tag_full, fifo_empty, fifo_full;
    occ_t occ;
    fetch_entry_t head;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= FS_BOOT;
        else
            state <= state_next;
    always_comb
        state_next = state == FS_BOOT ? FS_RUN : state;
    always_comb begin
        occ = {1'b0, inflight} + {1'b0, drop} + {1'b0, fifo_count};
        imem_req_valid = state == FS_RUN && !branch_taken && !tag_full && occ < CAP;
        imem_req_addr = fetch_pc;
        ins_valid = !fifo_empty && !branch_taken;
        ins = fifo_empty ? NOP_INS : head.ins;
        pc_out = fifo_empty ? '0 : head.pc;
    end
    // owed: responses still to be discarded, including everything in flight on a redirect
    always_comb begin
        req_fire = imem_req_valid && imem_req_ready;
        ins_fire = ins_valid && ins_ready;
        owed = branch_taken ? drop + inflight : drop;
        rsp_keep = imem_rsp_valid && owed == '0 && !branch_taken && !tag_empty;
        drop_next = owed - CW'(imem_rsp_valid && owed != '0);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            fetch_pc <= ResetVector;
            drop <= '0;
        end else begin
            drop <= drop_next;
            fetch_pc <= branch_taken ? branch_addr & ~WordSize'(INS_BYTES - 1)
                                     : fetch_pc + (req_fire ? WordSize'(INS_BYTES) : '0);
        end
    fetch_fifo #(.Depth(Depth), .T(logic [WordSize-1:0])) u_tags (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (rsp_keep),
        .flush (branch_taken),
        .din   (fetch_pc),
        .dout  (tag_head),
        .count (inflight),
        .empty (tag_empty),
        .full  (tag_full)
    );
    fetch_fifo #(.Depth(Depth), .T(fetch_entry_t)) u_words (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_keep),
        .pop   (ins_fire),
        .flush (branch_taken),
        .din   ('{pc: tag_head, ins: imem_rsp_data}),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );
    always @(posedge clk)
        if (!rst)
            assert (!fifo_full || (inflight == '0 && drop == '0));
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench with a latency-programmable memory model and redirect vectors
module tb_if_fetch_unit;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h00000013;
    logic clk = 0, rst = 0;
    logic branch_taken = 0, imem_req_valid, imem_req_ready = 1, imem_rsp_valid = 0;
    logic ins_valid, ins_ready = 1;
    logic [31:0] branch_addr = 0, imem_req_addr, imem_rsp_data = 0, ins, pc_out;

    if_fetch_unit #(.WordSize(32), .ResetVector(32'h0), .Depth(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins            (ins),
        .pc_out         (pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; int due;} mreq_t;
    typedef struct {logic [31:0] pc; logic [31:0] ins;} exp_t;
    typedef struct {
        string name;
        int lat;
        int min_fly;
        bit on_rsp;
        bit two;
        logic [31:0] tgt1, tgt2, exp_req, exp_req2, exp_pc;
    } vec_t;

    mreq_t mq[$];
    exp_t sb[$];
    vec_t tbl[4];
    int n_checks = 0, n_fail = 0, cyc = 0, lat = 1, n_del = 0;
    bit rdy_ins = 1, rdy_req = 1, br_now = 0, fired, delivered;
    logic [31:0] br_tgt = 0, exp_addr = 0, fired_addr, del_pc;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_ins_valid", ins_valid, 0);
        chk("rst_ins", ins, NOP);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_req_addr", imem_req_addr, 0);
    endtask

    // memory shares rst, so pending responses vanish with it
    task automatic apply_reset();
        #2 rst = 1;
        #1 chk_reset_outputs();
        imem_rsp_valid = 0;
        branch_taken = 0;
        br_now = 0;
        mq.delete();
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        #1 chk("boot_req_valid", imem_req_valid, 0);
        exp_addr = 0;
        cyc = 0;
    endtask

    // one cycle: drive inputs at negedge, then observe what the next posedge will commit
    task automatic step();
        exp_t e;
        @(negedge clk);
        imem_rsp_valid = mq.size() > 0 && mq[0].due <= cyc;
        imem_rsp_data = imem_rsp_valid ? data_of(mq[0].addr) : '0;
        ins_ready = rdy_ins;
        imem_req_ready = rdy_req;
        branch_taken = br_now;
        branch_addr = br_tgt;
        #1;
        fired = imem_req_valid && imem_req_ready;
        fired_addr = imem_req_addr;
        delivered = ins_valid && ins_ready;
        del_pc = pc_out;
        if (imem_rsp_valid) void'(mq.pop_front());
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_addr);
        if (fired) begin
            mq.push_back('{imem_req_addr, cyc + lat});
            sb.push_back('{exp_addr, data_of(exp_addr)});
            exp_addr += 4;
        end
        if (branch_taken) begin
            chk("br_req_valid", imem_req_valid, 0);
            chk("br_ins_valid", ins_valid, 0);
            sb.delete();
            exp_addr = {br_tgt[31:2], 2'b00};
        end
        if (delivered) begin
            n_del++;
            if (sb.size() == 0) chk("ins_without_request", ins_valid, 0);
            else begin
                e = sb.pop_front();
                chk("pc_out", pc_out, e.pc);
                chk("ins", ins, e.ins);
            end
        end
        cyc++;
        br_now = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int freq, fdel, nd, max_out, n0;
        tbl[0] = '{"redir_inflight", 3, 2, 0, 0, 32'h100, 32'h0, 32'h100, 32'h104, 32'h100};
        tbl[1] = '{"redir_on_rsp", 1, 0, 1, 0, 32'h203, 32'h0, 32'h200, 32'h204, 32'h200};
        tbl[2] = '{"redir_twice", 2, 1, 0, 1, 32'h40, 32'h80, 32'h80, 32'h84, 32'h80};
        tbl[3] = '{"redir_wrap", 1, 0, 0, 0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFC};
        apply_reset();
        freq = -1;
        fdel = -1;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (fired && freq < 0) freq = k;
            if (delivered && fdel < 0) fdel = k;
            if (delivered) nd++;
        end
        chk("first_req_cycle", freq, 0);
        chk("first_ins_cycle", fdel, 2);
        chk("burst_delivered", nd, 4);
        rdy_ins = 0;
        max_out = 0;
        repeat (10) begin
            step();
            if (sb.size() > max_out) max_out = sb.size();
        end
        chk("stall_outstanding", max_out, DEPTH);
        chk("stall_req_valid", imem_req_valid, 0);
        rdy_ins = 1;
        n0 = n_del;
        repeat (8) begin
            rdy_req = 1'($urandom_range(0, 1));
            step();
        end
        rdy_req = 1;
        chk("drain_delivered", n_del - n0 >= DEPTH, 1);
        for (int p = 0; p < 4; p++) begin
            bit ok, got_del;
            int got_req;
            logic [31:0] r0, r1, d0;
            lat = tbl[p].lat;
            repeat (10) step();
            ok = 0;
            for (int k = 0; k < 60 && !ok; k++) begin
                ok = tbl[p].on_rsp ? (mq.size() > 0 && mq[0].due <= cyc) : (mq.size() >= tbl[p].min_fly);
                if (!ok) step();
            end
            chk({tbl[p].name, "_setup"}, ok, 1);
            br_now = 1;
            br_tgt = tbl[p].tgt1;
            step();
            if (tbl[p].two) begin
                br_now = 1;
                br_tgt = tbl[p].tgt2;
                step();
            end
            got_req = 0;
            got_del = 0;
            r0 = 32'hDEADBEEF;
            r1 = 32'hDEADBEEF;
            d0 = 32'hDEADBEEF;
            for (int k = 0; k < 40 && !(got_req >= 2 && got_del); k++) begin
                step();
                if (fired && got_req == 1) r1 = fired_addr;
                if (fired && got_req == 0) r0 = fired_addr;
                if (fired && got_req < 2) got_req++;
                if (delivered && !got_del) begin
                    d0 = del_pc;
                    got_del = 1;
                end
            end
            chk({tbl[p].name, "_req0"}, r0, tbl[p].exp_req);
            chk({tbl[p].name, "_req1"}, r1, tbl[p].exp_req2);
            chk({tbl[p].name, "_first_pc"}, d0, tbl[p].exp_pc);
        end
        repeat (3) step();
        apply_reset();
        step();
        chk("post_rst_fire", fired, 1);
        chk("post_rst_addr", fired_addr, 0);
        repeat (6) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
